inst_mem_boot: RTL and testbench
================================

// Module: inst_mem_boot
// PURPOSE
// Loadable instruction memory feeding the core's fetch port. It sits directly upstream of the core.
// The core drives rom_ce_o/rom_addr_o into this block; this block returns rom_data_i.
// A byte-serial loader fills the memory after power-up and holds the core in reset until the load completes.
// PARAMETERS
// DEPTH_LOG2  10  log2 of memory depth in 32-bit words (default 1024 words)
// LEN_W       16  width of the ld_len word-count input
// BOOT_WAIT   1   1: core_rst_o is held high from reset until the first load completes; 0: core runs from reset
// PORTS
// clk          in   1   single clock; all state updates on rising edge
// rst          in   1   synchronous, active-high reset
// ce           in   1   fetch enable from core (rom_ce_o)
// addr         in   32  fetch byte address from core (rom_addr_o); word index = addr[DEPTH_LOG2+1:2]
// inst         out  32  instruction to core (rom_data_i)
// ld_start     in   1   one-cycle pulse that starts a load at word 0
// ld_len       in   LEN_W  number of words to load; sampled when ld_start is accepted
// ld_valid     in   1   loader byte valid
// ld_byte      in   8   loader byte
// ld_ready     out  1   block accepts ld_byte when ld_valid && ld_ready
// load_done    out  1   one-cycle pulse when a load finishes
// load_err     out  1   sticky flag: ld_len > 2**DEPTH_LOG2; cleared by rst or the next accepted ld_start
// core_rst_o   out  1   reset to the core; high while the core must not fetch
// BEHAVIOUR
// - Read path is combinational:
//   - inst = 0 when ce=0.
//   - inst = 0 when addr[31:DEPTH_LOG2+2] != 0 (out of range, treated as nop).
//   - Otherwise inst = mem[word index].
// - Memory array is not reset. Contents survive rst.
// - FSM states: IDLE, LOAD, DONE. Reset leads to IDLE.
// - Reset values:
//   - ld_ready=0, load_done=0, load_err=0.
//   - core_rst_o=BOOT_WAIT.
//   - Byte counter=0, word pointer=0, assembly register=0.
// - IDLE/DONE, ld_start=1, ld_len <= 2**DEPTH_LOG2, ld_len != 0:
//   - Go to LOAD. Latch ld_len. Clear counters. Clear load_err.
// - ld_start with ld_len == 0: go to DONE next cycle and pulse load_done. No writes.
// - ld_start with ld_len > depth: set load_err. State is unchanged. No writes.
// - ld_start is ignored in LOAD.
// - LOAD:
//   - ld_ready=1 and core_rst_o=1.
//   - A byte is counted only on the handshake ld_valid && ld_ready. Gaps in ld_valid are allowed.
//   - Bytes are big-endian: the first byte of each word is inst[31:24].
//   - On the edge accepting the 4th byte, write the word to mem[ptr], increment ptr and reset the byte counter.
//   - A written word is readable via inst in the following cycle.
//   - When the written word is number ld_len, the FSM enters DONE on that same edge.
// - Entering DONE: load_done=1 for exactly that first DONE cycle. ld_ready=0. core_rst_o=0 from that cycle on.
// - DONE with no ld_start: stay in DONE; core_rst_o=0.
// - BOOT_WAIT=0: core_rst_o=0 in IDLE as well. core_rst_o=1 only in LOAD.
// - rst mid-load:
//   - Next cycle state=IDLE and ld_ready=0. The partial word is discarded.
//   - Already-written words remain in memory.
//   - A subsequent load restarts at word 0, byte 0.
// - The loader never stalls: there is no backpressure in LOAD beyond ld_ready.
// TESTING
// - Reset, BOOT_WAIT=1 -> core_rst_o=1, ld_ready=0, load_done=0, load_err=0; ce=0 gives inst=0.
// - ld_start, ld_len=2, bytes 34 02 00 01 24 21 00 02 on back-to-back cycles
//   -> load_done pulses one cycle after the 8th byte; core_rst_o falls in that cycle;
//   -> ce=1, addr=0x0 gives inst=0x34020001; addr=0x4 gives 0x24210002.
// - Same load with random 0-3 cycle ld_valid gaps -> identical memory contents and a single load_done pulse.
// - ld_len=2**DEPTH_LOG2+1 -> load_err=1, ld_ready stays 0, memory unchanged; a later valid ld_start clears load_err.
// - rst after 5 accepted bytes -> IDLE; mem[0] holds the first word; new load with ld_len=1, bytes AA BB CC DD
//   -> mem[0]=0xAABBCCDD.
// - ld_start pulsed mid-LOAD -> ignored.
// - addr=0x4 << DEPTH_LOG2 (first address past the end) with ce=1 -> inst=0.
// - ld_len=0 -> load_done pulse the next cycle, no write.

Source files
------------

// File: rtl/inst_mem_boot_if.sv
// Fetch and loader bus between the core/boot loader and the instruction memory.
// Latency: n/a (signal bundle only).
// Backpressure: loader bytes move only on ld_valid && ld_ready; fetch has none.
// Ports: fetch (ce, addr -> inst); loader (ld_start, ld_len, ld_valid, ld_byte -> ld_ready,
//        load_done, load_err). The slave modport is the memory, the master modport drives it.
interface inst_mem_boot_if #(
    parameter int LEN_W = 16
);
    logic             ce;
    logic [31:0]      addr;
    logic [31:0]      inst;
    logic             ld_start;
    logic [LEN_W-1:0] ld_len;
    logic             ld_valid;
    logic [7:0]       ld_byte;
    logic             ld_ready;
    logic             load_done;
    logic             load_err;

    modport slave (
        input  ce, addr, ld_start, ld_len, ld_valid, ld_byte,
        output inst, ld_ready, load_done, load_err
    );

    modport master (
        output ce, addr, ld_start, ld_len, ld_valid, ld_byte,
        input  inst, ld_ready, load_done, load_err
    );
endinterface

// File: rtl/inst_mem_boot.sv
// Loadable instruction memory; byte-serial loader fills it and holds the core in reset meanwhile.
// Latency: fetch is combinational; a loaded word is readable the cycle after its 4th byte.
// Backpressure: ld_ready is high only in LOAD; the loader is never stalled inside LOAD.
// Ports: clk, rst (sync, active-high); bus (slave modport: fetch + loader signals);
//        core_rst_o holds the core in reset while it must not fetch.
module inst_mem_boot #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LEN_W      = 16,
    parameter bit BOOT_WAIT  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_mem_boot_if.slave        bus,
    output logic                  core_rst_o
);
    localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [31:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [23:0]           asm_q, asm_d;    // first three bytes of the word in flight
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  mem_we;
    logic [31:0]           mem_wdata;
    logic                  last_word;

    // Byte offset bits never select anything: fetch is word-granular.
    logic unused_addr;
    assign unused_addr = ^bus.addr[1:0];

    // Combinational fetch; anything above the array decodes to a zero (nop) word.
    always_comb begin
        bus.inst = 32'd0;
        if (bus.ce && (bus.addr[31:DEPTH_LOG2+2] == '0)) begin
            bus.inst = mem[bus.addr[DEPTH_LOG2+1:2]];
        end
    end

    assign last_word = (32'(ptr_q) + 32'd1) == 32'(len_q);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        ptr_d     = ptr_q;
        bcnt_d    = bcnt_q;
        asm_d     = asm_q;
        done_d    = 1'b0;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_wdata = {asm_q, bus.ld_byte};

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.ld_start) begin
                    if (32'(bus.ld_len) > DEPTH) begin
                        err_d = 1'b1;
                    end else if (bus.ld_len == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_LOAD;
                        len_d   = bus.ld_len;
                        ptr_d   = '0;
                        bcnt_d  = '0;
                        asm_d   = '0;
                        err_d   = 1'b0;
                    end
                end
            end
            ST_LOAD: begin
                if (bus.ld_valid) begin
                    if (bcnt_q == 2'd3) begin
                        // A reset on this edge must not commit the word.
                        mem_we = !rst;
                        ptr_d  = ptr_q + 1'b1;
                        bcnt_d = '0;
                        asm_d  = '0;
                        if (last_word) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        asm_d  = {asm_q[15:0], bus.ld_byte};
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.ld_ready  = (state_q == ST_LOAD);
    assign bus.load_done = done_q;
    assign bus.load_err  = err_q;
    assign core_rst_o    = (state_q == ST_LOAD) || ((state_q == ST_IDLE) && BOOT_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            ptr_q   <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset so a warm reset keeps the loaded program.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q] <= mem_wdata;
        end
    end
endmodule

// File: tb/tb_inst_mem_boot.sv
// Scoreboard bench for inst_mem_boot: directed loads, reads, error, abort and restart cases.
// Latency: reads sampled the same cycle; status probes sampled mid-cycle.
// Backpressure: loader bytes are only offered while the DUT is in LOAD.
module tb_inst_mem_boot;
    localparam int DEPTH_LOG2 = 10;
    localparam int LEN_W      = 16;

    typedef struct {
        string       name;
        logic [35:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic core_rst_o;
    logic probe = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    exp_t rd_q[$];
    exp_t st_q[$];
    exp_t dn_q[$];

    inst_mem_boot_if #(.LEN_W(LEN_W)) bus ();

    inst_mem_boot #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .LEN_W     (LEN_W),
        .BOOT_WAIT (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .core_rst_o(core_rst_o)
    );

    always #5 clk = ~clk;

    initial begin
        bus.ce       = 1'b0;
        bus.addr     = 32'd0;
        bus.ld_start = 1'b0;
        bus.ld_len   = '0;
        bus.ld_valid = 1'b0;
        bus.ld_byte  = 8'd0;
    end

    function automatic void check(string name, logic [35:0] act, logic [35:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents a fetch, a done pulse or a probe.
    always @(negedge clk) begin
        exp_t e;
        if (bus.ce) begin
            if (rd_q.size() == 0) check("unexpected_read", {4'h0, bus.inst}, 36'h0);
            else begin
                e = rd_q.pop_front();
                check(e.name, {4'h0, bus.inst}, e.exp);
            end
        end
        if (bus.load_done) begin
            if (dn_q.size() == 0) check("unexpected_load_done", 36'h1, 36'h0);
            else begin
                e = dn_q.pop_front();
                check(e.name, {34'h0, core_rst_o, bus.ld_ready}, e.exp);
            end
        end
        if (probe) begin
            if (st_q.size() == 0) check("unexpected_probe", 36'h1, 36'h0);
            else begin
                e = st_q.pop_front();
                check(e.name, {core_rst_o, bus.ld_ready, bus.load_done, bus.load_err, bus.inst}, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status probe: {core_rst_o, ld_ready, load_done, load_err} with ce low so inst must be 0.
    task automatic status(string name, logic [3:0] st);
        exp_t e;
        e.name = name;
        e.exp  = {st, 32'h0};
        st_q.push_back(e);
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    task automatic rd(string name, logic [31:0] a, logic [31:0] d);
        exp_t e;
        e.name = name;
        e.exp  = {4'h0, d};
        rd_q.push_back(e);
        bus.addr = a;
        bus.ce   = 1'b1;
        tick();
        bus.ce   = 1'b0;
    endtask

    // A done pulse must see core_rst_o=0 and ld_ready=0.
    task automatic expect_done(string name);
        exp_t e;
        e.name = name;
        e.exp  = 36'h0;
        dn_q.push_back(e);
    endtask

    task automatic start(int len);
        bus.ld_start = 1'b1;
        bus.ld_len   = LEN_W'(len);
        tick();
        bus.ld_start = 1'b0;
    endtask

    task automatic send_byte(logic [7:0] b, int gap);
        bus.ld_valid = 1'b0;
        repeat (gap) tick();
        bus.ld_valid = 1'b1;
        bus.ld_byte  = b;
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic send_bytes(logic [7:0] b[$], bit gaps);
        foreach (b[i]) send_byte(b[i], gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] w2[$];
        logic [7:0] w1[$];
        tick();
        tick();
        rst = 1'b0;
        status("reset_state", 4'b1000);

        // Back-to-back load of two words.
        w2 = '{8'h34, 8'h02, 8'h00, 8'h01, 8'h24, 8'h21, 8'h00, 8'h02};
        start(2);
        status("load_busy", 4'b1100);
        expect_done("done_a_outputs");
        send_bytes(w2, 1'b0);
        status("done_a_pulse", 4'b0010);
        status("done_a_after", 4'b0000);
        rd("rd_a_w0", 32'h0, 32'h34020001);
        rd("rd_a_w1", 32'h4, 32'h24210002);

        // Overwrite word 0, then reload the same program with random gaps.
        w1 = '{8'h11, 8'h22, 8'h33, 8'h44};
        start(1);
        expect_done("done_b_outputs");
        send_bytes(w1, 1'b0);
        rd("rd_b_w0", 32'h0, 32'h11223344);
        rd("rd_b_w1", 32'h4, 32'h24210002);
        start(2);
        expect_done("done_c_outputs");
        send_bytes(w2, 1'b1);
        status("done_c_pulse", 4'b0010);
        rd("rd_c_w0", 32'h0, 32'h34020001);
        rd("rd_c_w1", 32'h4, 32'h24210002);

        // Oversized length flags an error and leaves memory and state alone.
        start((1 << DEPTH_LOG2) + 1);
        status("err_set", 4'b0001);
        status("err_sticky", 4'b0001);
        rd("rd_err_w0", 32'h0, 32'h34020001);

        // Zero length: immediate done, no write, error cleared.
        start(0);
        expect_done("done_zero_outputs");
        status("done_zero_pulse", 4'b0010);
        rd("rd_zero_w0", 32'h0, 32'h34020001);

        // ld_start in the middle of a load is ignored.
        start(2);
        send_bytes('{8'h01, 8'h02, 8'h03, 8'h04}, 1'b0);
        start(1);
        status("mid_start_ignored", 4'b1100);
        expect_done("done_mid_outputs");
        send_bytes('{8'h05, 8'h06, 8'h07, 8'h08}, 1'b0);
        rd("rd_mid_w0", 32'h0, 32'h01020304);
        rd("rd_mid_w1", 32'h4, 32'h05060708);

        // Reset after five bytes: first word kept, partial word dropped.
        start(2);
        send_bytes('{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB5}, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        status("abort_idle", 4'b1000);
        rd("rd_abort_w0", 32'h0, 32'hA1A2A3A4);
        rd("rd_abort_w1", 32'h4, 32'h05060708);
        start(1);
        expect_done("done_restart_outputs");
        send_bytes('{8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1'b0);
        status("done_restart_pulse", 4'b0010);
        rd("rd_restart_w0", 32'h0, 32'hAABBCCDD);
        rd("rd_restart_w1", 32'h4, 32'h05060708);

        // Out-of-range fetch addresses return a nop.
        rd("rd_past_end", 32'h4 << DEPTH_LOG2, 32'h0);
        rd("rd_high_addr", 32'h8000_0000, 32'h0);

        tick();
        tick();
        if (rd_q.size() != 0) check("reads_pending", 36'(rd_q.size()), 36'h0);
        if (st_q.size() != 0) check("probes_pending", 36'(st_q.size()), 36'h0);
        if (dn_q.size() != 0) check("load_done_missing", 36'(dn_q.size()), 36'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
